stack_op_sequencer: RTL

Command sequencer that executes stack-machine operations on the data stack. It accepts one opcode per handshake and issues the push/pop pulse sequence to the stack. For arithmetic ops it computes the result internally and pushes it back. It tracks stack depth and rejects underflow/overflow before touching the stack, so the stack never receives an illegal pulse.

---
 rtl/stack_op_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/stack_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_op_sequencer
// Purpose  : Executes stack-machine opcodes against an external data stack.
//            Each accepted command is legality-checked against the tracked
//            depth, then expanded into the pop / compute / push pulse sequence.
//            Illegal commands complete with an error code and never pulse
//            the stack.
// Ports    : clk, rst_n             - clock, async active-low reset
//            cmd_valid/ready/op/imm - command handshake (ready only in IDLE)
//            push_sig, push_data    - one-cycle push pulse and its data
//            pop_sig, stk_data      - one-cycle pop pulse; data returns next cycle
//            done, err, result      - completion pulse with status and value
//            depth, full, empty     - logical stack occupancy
// Revision : 1.0 - initial release
// ============================================================================
module stack_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             push_sig,
  output logic             pop_sig,
  output logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] stk_data,
  output logic             done,
  output logic [1:0]       err,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  localparam logic [2:0] c_op_push = 3'b000;
  localparam logic [2:0] c_op_pop  = 3'b001;
  localparam logic [2:0] c_op_add  = 3'b010;
  localparam logic [2:0] c_op_sub  = 3'b011;
  localparam logic [2:0] c_op_and  = 3'b100;
  localparam logic [2:0] c_op_or   = 3'b101;
  localparam logic [2:0] c_op_not  = 3'b110;
  localparam logic [2:0] c_op_dup  = 3'b111;

  localparam logic [1:0] c_err_ok    = 2'b00;
  localparam logic [1:0] c_err_under = 2'b01;
  localparam logic [1:0] c_err_over  = 2'b10;

  localparam logic [CW-1:0] c_depth_max = CW'(DEPTH);
  localparam logic [CW-1:0] c_one       = CW'(1);
  localparam logic [CW-1:0] c_two       = CW'(2);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_POP1  = 4'd1,
    S_WAIT1 = 4'd2,
    S_POP2  = 4'd3,
    S_WAIT2 = 4'd4,
    S_PUSH  = 4'd5,
    S_PUSH2 = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic [1:0]       legal_err;

  // Legality of the offered op against the current depth. Underflow is
  // tested before overflow so DUP on an empty stack reports underflow.
  always_comb begin
    legal_err = c_err_ok;
    case (cmd_op)
      c_op_push: if (depth_q == c_depth_max) legal_err = c_err_over;
      c_op_pop,
      c_op_not:  if (depth_q == '0) legal_err = c_err_under;
      c_op_dup: begin
        if (depth_q == '0)               legal_err = c_err_under;
        else if (depth_q == c_depth_max) legal_err = c_err_over;
      end
      default:   if (depth_q < c_two) legal_err = c_err_under;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= c_op_push;
      err_q   <= c_err_ok;
      res_q   <= '0;
      a_q     <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      res_q   <= res_d;
      a_q     <= a_d;
      depth_q <= depth_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    err_d     = err_q;
    res_d     = res_q;
    a_d       = a_q;
    depth_d   = depth_q;
    cmd_ready = 1'b0;
    push_sig  = 1'b0;
    pop_sig   = 1'b0;
    push_data = '0;
    done      = 1'b0;
    err       = c_err_ok;
    result    = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = cmd_op;
          err_d = legal_err;
          if (legal_err != c_err_ok) begin
            state_d = S_ERR;
          end else if (cmd_op == c_op_push) begin
            res_d   = cmd_imm;
            state_d = S_PUSH;
          end else begin
            state_d = S_POP1;
          end
        end
      end
      S_POP1: begin
        pop_sig = 1'b1;
        depth_d = depth_q - c_one;
        state_d = S_WAIT1;
      end
      // Old top of stack arrives here; it is operand A for binary ops.
      S_WAIT1: begin
        a_d = stk_data;
        case (op_q)
          c_op_pop: begin
            res_d   = stk_data;
            state_d = S_DONE;
          end
          c_op_not: begin
            res_d   = ~stk_data;
            state_d = S_PUSH;
          end
          c_op_dup: begin
            res_d   = stk_data;
            state_d = S_PUSH;
          end
          default: state_d = S_POP2;
        endcase
      end
      S_POP2: begin
        pop_sig = 1'b1;
        depth_d = depth_q - c_one;
        state_d = S_WAIT2;
      end
      // Element beneath the old top is operand B; result is B op A.
      S_WAIT2: begin
        case (op_q)
          c_op_add: res_d = stk_data + a_q;
          c_op_sub: res_d = stk_data - a_q;
          c_op_and: res_d = stk_data & a_q;
          c_op_or:  res_d = stk_data | a_q;
          default:  res_d = res_q;
        endcase
        state_d = S_PUSH;
      end
      S_PUSH: begin
        push_sig  = 1'b1;
        push_data = res_q;
        depth_d   = depth_q + c_one;
        state_d   = (op_q == c_op_dup) ? S_PUSH2 : S_DONE;
      end
      S_PUSH2: begin
        push_sig  = 1'b1;
        push_data = res_q;
        depth_d   = depth_q + c_one;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        result  = res_q;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign depth = depth_q;
  assign full  = (depth_q == c_depth_max);
  assign empty = (depth_q == '0);

endmodule
`default_nettype wire
